imem_resp: RTL and testbench
============================

IMEM_RESP -- requirements
Module: imem_resp

Interface
REQ-001 Parameter DEPTH_LOG2, default 8, log2 of word count of the instruction array (256 x 32).
REQ-002 Parameter WAIT_CYCLES, default 2, wait states inserted before each fetch response; legal range 0..15.
REQ-003 clk  input  1  system clock; all state changes on rising edge.
REQ-004 rst_f  input  1  reset; one clock, reset asynchronous and active-low.
REQ-005 req  input  1  fetch request from processor; level, sampled only in IDLE.
REQ-006 addr  input  16  fetch word address; captured on request accept.
REQ-007 ack  output  1  one-cycle pulse; rdata valid in that cycle.
REQ-008 rdata  output  32  fetched instruction word; registered, holds until next ack.
REQ-009 busy  output  1  high while a fetch is pending (WAIT or ACK state).
REQ-010 ld_we  input  1  program-load write enable.
REQ-011 ld_addr  input  16  program-load word address.
REQ-012 ld_data  input  32  program-load data.
REQ-013 err  output  1  out-of-range flag, pulses with ack (see Configuration).

Function
REQ-014 FSM states: IDLE, WAIT, ACK; registered state, no other states.
REQ-015 IDLE: req=1 at edge -> addr_q<=addr, cnt<=WAIT_CYCLES, next WAIT (WAIT_CYCLES>0) or ACK (WAIT_CYCLES=0); req=0 -> stay IDLE.
REQ-016 WAIT: cnt decrements each edge; at edge with cnt=1 -> ACK; cnt never underflows.
REQ-017 ACK: ack=1 for exactly one cycle; next edge -> IDLE unconditionally.
REQ-018 Latency: ack high in cycle WAIT_CYCLES+1 after accept edge; accept-to-accept minimum WAIT_CYCLES+2 cycles.
REQ-019 req and addr ignored in WAIT and ACK; addr changes after accept have no effect.
REQ-020 rdata loaded on edge entering ACK with mem[addr_q]; unchanged at all other edges.
REQ-021 ld_we=1 writes ld_data to mem[ld_addr] at edge, in any state, independent of fetch.
REQ-022 Same-edge load and rdata capture to same address: rdata receives ld_data (write-first forwarding).
REQ-023 Load to addr_q during WAIT: response returns the newly written word.
REQ-024 busy = (state != IDLE), combinational from state register.
REQ-025 No read-modify paths; memory array is not reset.

Reset
REQ-026 rst_f low: state IDLE, cnt 0, addr_q 0, ack 0, busy 0, rdata 32'h00000000, err 0, immediately (no clock).
REQ-027 Reset during WAIT or ACK aborts fetch; no ack after release.
REQ-028 First request accepted at first rising edge with rst_f high and req high.

Configuration
REQ-029 Macro IMEM_RANGE_CHK_EN defined: fetch with addr >= 2**DEPTH_LOG2 gives rdata 32'h00000000 and err=1 in ACK cycle; load with ld_addr out of range is dropped.
REQ-030 IMEM_RANGE_CHK_EN undefined: fetch and load addresses truncated to low DEPTH_LOG2 bits (wrap); err tied 0.

Verification
REQ-031 Reset, load mem[5]=32'h12345678, req with addr=5, WAIT_CYCLES=2 -> ack in 3rd cycle after accept, rdata=32'h12345678, busy high 3 cycles.
REQ-032 WAIT_CYCLES=0, req held high with addr=1 then 2, mem[1]=A1, mem[2]=B2 -> ack every 2nd cycle, rdata A1 then B2, no request lost.
REQ-033 Fetch addr=7 pending, ld_we writes mem[7]=32'hDEADBEEF during WAIT -> rdata=32'hDEADBEEF.
REQ-034 rst_f low one cycle into WAIT -> ack never asserted, rdata=0, busy=0 asynchronously.
REQ-035 addr=16'h0105, mem[5]=32'hCAFE0001: with IMEM_RANGE_CHK_EN -> rdata=0, err=1; without -> rdata=32'hCAFE0001, err=0.
REQ-036 addr changed to 9 during WAIT of fetch to 3 -> rdata=mem[3].

Source files
------------

// File: rtl/imem_resp.sv
// imem_resp: instruction memory with a fixed wait-state fetch handshake and a program-load port.
// Optional IMEM_RANGE_CHK_EN: out-of-range fetches return 0 with err, out-of-range loads are dropped.
// Revision: 1.0
`default_nettype none

module imem_resp #(
  parameter int DEPTH_LOG2  = 8,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst_f,
  input  logic        req,
  input  logic [15:0] addr,
  output logic        ack,
  output logic [31:0] rdata,
  output logic        busy,
  input  logic        ld_we,
  input  logic [15:0] ld_addr,
  input  logic [31:0] ld_data,
  output logic        err
);

  localparam int DEPTH = 1 << DEPTH_LOG2;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_ACK  = 2'd2;

  logic [1:0]            state_q, state_d;
  logic [3:0]            cnt_q, cnt_d;
  logic [15:0]           addr_q, addr_d;
  logic [31:0]           rdata_q, rdata_d;
  logic                  err_q, err_d;

  logic [31:0]           mem [DEPTH];

  logic [15:0]           w_rd_addr;
  logic [DEPTH_LOG2-1:0] w_rd_idx;
  logic [DEPTH_LOG2-1:0] w_ld_idx;
  logic                  w_rd_oor;
  logic                  w_ld_ok;
  logic                  w_fwd;

  // In IDLE with WAIT_CYCLES=0 the word is captured on the accept edge itself, before addr_q exists.
  assign w_rd_addr = (state_q == S_IDLE) ? addr : addr_q;
  assign w_rd_idx  = w_rd_addr[DEPTH_LOG2-1:0];
  assign w_ld_idx  = ld_addr[DEPTH_LOG2-1:0];

`ifdef IMEM_RANGE_CHK_EN
  assign w_rd_oor = (32'(w_rd_addr) >= DEPTH);
  assign w_ld_ok  = ld_we && (32'(ld_addr) < DEPTH);
  assign err      = err_q && (state_q == S_ACK);
`else
  logic unused_ok;
  assign w_rd_oor  = 1'b0;
  assign w_ld_ok   = ld_we;
  assign err       = 1'b0;
  assign unused_ok = ^{addr, addr_q, ld_addr, err_q};
`endif

  assign w_fwd = w_ld_ok && (w_ld_idx == w_rd_idx);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    case (state_q)
      S_IDLE: begin
        if (req) begin
          addr_d  = addr;
          cnt_d   = 4'(WAIT_CYCLES);
          state_d = (WAIT_CYCLES == 0) ? S_ACK : S_WAIT;
        end
      end
      S_WAIT: begin
        if (cnt_q <= 4'd1) begin
          cnt_d   = 4'd0;
          state_d = S_ACK;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      S_ACK:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    // ACK always returns to IDLE, so a next state of ACK means this edge enters it.
    if (state_d == S_ACK) begin
      err_d = w_rd_oor;
      if (w_rd_oor)   rdata_d = 32'h0000_0000;
      else if (w_fwd) rdata_d = ld_data;
      else            rdata_d = mem[w_rd_idx];
    end
  end

  always_ff @(posedge clk or negedge rst_f) begin
    if (!rst_f) begin
      state_q <= S_IDLE;
      cnt_q   <= 4'd0;
      addr_q  <= 16'h0000;
      rdata_q <= 32'h0000_0000;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  always_ff @(posedge clk) begin
    if (w_ld_ok) mem[w_ld_idx] <= ld_data;
  end

  assign ack   = (state_q == S_ACK);
  assign busy  = (state_q != S_IDLE);
  assign rdata = rdata_q;

endmodule

`default_nettype wire

// File: tb/tb_imem_resp.sv
// tb_imem_resp: two instances (WAIT_CYCLES=2 and 0) driven together and checked against a fetch model.
`default_nettype none
`timescale 1ns/1ps

module tb_imem_resp;

  logic        clk = 1'b0;
  logic        rst_f, req, ld_we;
  logic [15:0] addr, ld_addr;
  logic [31:0] ld_data;
  logic        ack2, busy2, err2, ack0, busy0, err0;
  logic [31:0] rdata2, rdata0;

  always #5 clk = ~clk;

  imem_resp #(.DEPTH_LOG2(8), .WAIT_CYCLES(2)) u_dut2 (
    .clk(clk), .rst_f(rst_f), .req(req), .addr(addr), .ack(ack2), .rdata(rdata2),
    .busy(busy2), .ld_we(ld_we), .ld_addr(ld_addr), .ld_data(ld_data), .err(err2));

  imem_resp #(.DEPTH_LOG2(8), .WAIT_CYCLES(0)) u_dut0 (
    .clk(clk), .rst_f(rst_f), .req(req), .addr(addr), .ack(ack0), .rdata(rdata0),
    .busy(busy0), .ld_we(ld_we), .ld_addr(ld_addr), .ld_data(ld_data), .err(err0));

  int checks = 0;
  int errors = 0;

  // Model: a fetch is "pending" for WC+1 cycles after its accept edge; the last one is the ack cycle.
  logic [31:0] m_mem [256];
  int          m_wc  [2];
  bit          m_pend[2];
  int          m_i   [2];
  logic [15:0] m_a   [2];
  logic [31:0] m_rd  [2];
  bit          m_err [2];

  typedef struct {
    bit          req;
    logic [15:0] addr;
    bit          ld_we;
    logic [15:0] ld_addr;
    logic [31:0] ld_data;
    bit          e_ack;
    bit          e_busy;
    bit          chk_rd;
    logic [31:0] e_rdata;
  } vec_t;

  vec_t vecs [17];

  function automatic bit oor(input logic [15:0] a);
`ifdef IMEM_RANGE_CHK_EN
    return (a >= 16'd256);
`else
    return (a == 16'hFFFF) && 1'b0;
`endif
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic m_reset();
    for (int k = 0; k < 2; k++) begin
      m_pend[k] = 1'b0;
      m_i[k]    = 0;
      m_a[k]    = 16'h0;
      m_rd[k]   = 32'h0;
      m_err[k]  = 1'b0;
    end
  endtask

  task automatic model_edge();
    if (!rst_f) begin
      m_reset();
      return;
    end
    if (ld_we && !oor(ld_addr)) m_mem[ld_addr[7:0]] = ld_data;
    for (int k = 0; k < 2; k++) begin
      if (!m_pend[k]) begin
        if (req) begin
          m_pend[k] = 1'b1;
          m_i[k]    = 1;
          m_a[k]    = addr;
        end
      end else if (m_i[k] == m_wc[k] + 1) begin
        m_pend[k] = 1'b0;
      end else begin
        m_i[k]++;
      end
      if (m_pend[k] && m_i[k] == m_wc[k] + 1) begin
        m_err[k] = oor(m_a[k]);
        m_rd[k]  = m_err[k] ? 32'h0 : m_mem[m_a[k][7:0]];
      end
    end
  endtask

  task automatic compare_all();
    bit ea2, ea0;
    ea2 = m_pend[0] && (m_i[0] == m_wc[0] + 1);
    ea0 = m_pend[1] && (m_i[1] == m_wc[1] + 1);
    chk("ack_wc2",   32'(ack2),  32'(ea2));
    chk("busy_wc2",  32'(busy2), 32'(m_pend[0]));
    chk("err_wc2",   32'(err2),  32'(ea2 && m_err[0]));
    chk("rdata_wc2", rdata2,     m_rd[0]);
    chk("ack_wc0",   32'(ack0),  32'(ea0));
    chk("busy_wc0",  32'(busy0), 32'(m_pend[1]));
    chk("err_wc0",   32'(err0),  32'(ea0 && m_err[1]));
    chk("rdata_wc0", rdata0,     m_rd[1]);
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    compare_all();
  endtask

  task automatic idle(input int n);
    req   = 1'b0;
    ld_we = 1'b0;
    repeat (n) tick();
  endtask

  task automatic set_vec(input vec_t v);
    req     = v.req;
    addr    = v.addr;
    ld_we   = v.ld_we;
    ld_addr = v.ld_addr;
    ld_data = v.ld_data;
  endtask

  initial begin
    int seen;
    int acks;
    m_wc[0] = 2;
    m_wc[1] = 0;
    m_reset();

    // {req, addr, ld_we, ld_addr, ld_data, e_ack, e_busy, chk_rd, e_rdata} for the WAIT_CYCLES=2 instance
    vecs[0]  = '{0, 16'h0000, 1, 16'h0005, 32'h12345678, 0, 0, 0, 32'h0};
    vecs[1]  = '{1, 16'h0005, 0, 16'h0000, 32'h0,        0, 1, 0, 32'h0};
    vecs[2]  = '{0, 16'hFFFF, 0, 16'h0000, 32'h0,        0, 1, 0, 32'h0};
    vecs[3]  = '{1, 16'h0009, 0, 16'h0000, 32'h0,        1, 1, 1, 32'h12345678};
    vecs[4]  = '{0, 16'h0000, 0, 16'h0000, 32'h0,        0, 0, 1, 32'h12345678};
    vecs[5]  = '{1, 16'h0007, 0, 16'h0000, 32'h0,        0, 1, 0, 32'h0};
    vecs[6]  = '{0, 16'h0000, 1, 16'h0007, 32'hDEADBEEF, 0, 1, 0, 32'h0};
    vecs[7]  = '{0, 16'h0000, 0, 16'h0000, 32'h0,        1, 1, 1, 32'hDEADBEEF};
    vecs[8]  = '{0, 16'h0000, 0, 16'h0000, 32'h0,        0, 0, 1, 32'hDEADBEEF};
    vecs[9]  = '{1, 16'h0003, 1, 16'h0003, 32'h33333333, 0, 1, 0, 32'h0};
    vecs[10] = '{1, 16'h0009, 1, 16'h0009, 32'h99999999, 0, 1, 0, 32'h0};
    vecs[11] = '{0, 16'h0009, 0, 16'h0000, 32'h0,        1, 1, 1, 32'h33333333};
    vecs[12] = '{0, 16'h0000, 0, 16'h0000, 32'h0,        0, 0, 1, 32'h33333333};
    vecs[13] = '{1, 16'h0020, 0, 16'h0000, 32'h0,        0, 1, 0, 32'h0};
    vecs[14] = '{0, 16'h0000, 0, 16'h0000, 32'h0,        0, 1, 0, 32'h0};
    vecs[15] = '{0, 16'h0000, 1, 16'h0020, 32'hF0F0F0F0, 1, 1, 1, 32'hF0F0F0F0};
    vecs[16] = '{0, 16'h0000, 0, 16'h0000, 32'h0,        0, 0, 1, 32'hF0F0F0F0};

    rst_f = 1'b0; req = 1'b0; addr = 16'h0; ld_we = 1'b0; ld_addr = 16'h0; ld_data = 32'h0;
    @(negedge clk);
    compare_all();
    @(negedge clk);
    rst_f = 1'b1;

    // Fill the whole array so every later fetch has a known expected word.
    for (int a = 0; a < 256; a++) begin
      ld_we = 1'b1; ld_addr = 16'(a); ld_data = $urandom;
      tick();
    end
    idle(2);

    for (int n = 0; n < 17; n++) begin
      set_vec(vecs[n]);
      tick();
      chk($sformatf("vec%0d_ack", n),  32'(ack2),  32'(vecs[n].e_ack));
      chk($sformatf("vec%0d_busy", n), 32'(busy2), 32'(vecs[n].e_busy));
      if (vecs[n].chk_rd) chk($sformatf("vec%0d_rdata", n), rdata2, vecs[n].e_rdata);
    end
    idle(4);

    // Back-to-back with zero wait states: request held, address switched after each ack.
    ld_we = 1'b1; ld_addr = 16'h0001; ld_data = 32'h000000A1; tick();
    ld_addr = 16'h0002; ld_data = 32'h000000B2; tick();
    ld_we = 1'b0; idle(4);
    req = 1'b1; addr = 16'h0001; tick();
    chk("b2b_ack1", 32'(ack0), 32'd1);
    chk("b2b_rd1",  rdata0,    32'h000000A1);
    addr = 16'h0002; tick();
    chk("b2b_gap", 32'(ack0), 32'd0);
    tick();
    chk("b2b_ack2", 32'(ack0), 32'd1);
    chk("b2b_rd2",  rdata0,    32'h000000B2);
    idle(4);

    // Out-of-range fetch whose low bits alias word 5.
    ld_we = 1'b1; ld_addr = 16'h0005; ld_data = 32'hCAFE0001; tick();
    ld_we = 1'b0; req = 1'b1; addr = 16'h0105; tick();
    req = 1'b0;
    seen = 0;
    for (int c = 0; c < 10 && seen == 0; c++) begin
      if (ack2) seen = 1;
      else tick();
    end
    chk("oor_ack_seen", 32'(seen), 32'd1);
`ifdef IMEM_RANGE_CHK_EN
    chk("oor_rdata", rdata2,    32'h00000000);
    chk("oor_err",   32'(err2), 32'd1);
`else
    chk("oor_rdata", rdata2,    32'hCAFE0001);
    chk("oor_err",   32'(err2), 32'd0);
`endif
    idle(4);

    // Asynchronous reset while the fetch sits in WAIT.
    req = 1'b1; addr = 16'h0005; tick();
    req = 1'b0;
    #2 rst_f = 1'b0;
    #1;
    chk("arst_busy",  32'(busy2), 32'd0);
    chk("arst_ack",   32'(ack2),  32'd0);
    chk("arst_rdata", rdata2,     32'h0);
    m_reset();
    tick();
    rst_f = 1'b1;
    acks = 0;
    for (int c = 0; c < 6; c++) begin
      tick();
      if (ack2) acks++;
    end
    chk("arst_no_ack", 32'(acks), 32'd0);

    for (int c = 0; c < 3000; c++) begin
      req     = ($urandom_range(0, 3) != 0);
      addr    = 16'($urandom_range(0, 15) == 0 ? $urandom : $urandom_range(0, 255));
      ld_we   = ($urandom_range(0, 3) == 0);
      ld_addr = 16'($urandom_range(0, 15) == 0 ? $urandom : $urandom_range(0, 255));
      ld_data = $urandom;
      tick();
    end
    idle(4);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
